// File: rtl/nec_ir_decoder_if.sv
// rtl/nec_ir_decoder_if.sv - NEC IR decoder result bundle
interface nec_ir_decoder_if;
    logic [31:0] o_data;
    logic        o_valid;
    logic        o_repeat;
    logic        o_err;
    logic        o_busy;

    modport master (output o_data, output o_valid, output o_repeat, output o_err, output o_busy);
    modport slave  (input  o_data, input  o_valid, input  o_repeat, input  o_err, input  o_busy);
endinterface

// File: rtl/nec_ir_decoder.sv
// rtl/nec_ir_decoder.sv - NEC infrared frame / repeat-code receiver
// WIN_DIV divides every timing window; 1 gives standard NEC microsecond windows.
module nec_ir_decoder #(
    parameter int CLK_DIV   = 50,
    parameter int CHECK_CMD = 1,
    parameter int EXT_ADDR  = 0,
    parameter int WIN_DIV   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_ir_rxb,
    nec_ir_decoder_if.master bus
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [15:0] LM_MIN = 16'(8000 / WIN_DIV);
    localparam logic [15:0] LM_MAX = 16'(10000 / WIN_DIV);
    localparam logic [15:0] LS_MIN = 16'(4000 / WIN_DIV);
    localparam logic [15:0] LS_MAX = 16'(5000 / WIN_DIV);
    localparam logic [15:0] RS_MIN = 16'(2000 / WIN_DIV);
    localparam logic [15:0] RS_MAX = 16'(2500 / WIN_DIV);
    localparam logic [15:0] BM_MIN = 16'(400 / WIN_DIV);
    localparam logic [15:0] BM_MAX = 16'(700 / WIN_DIV);
    localparam logic [15:0] S0_MIN = 16'(400 / WIN_DIV);
    localparam logic [15:0] S0_MAX = 16'(700 / WIN_DIV);
    localparam logic [15:0] S1_MIN = 16'(1400 / WIN_DIV);
    localparam logic [15:0] S1_MAX = 16'(1900 / WIN_DIV);

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        REP_MARK
    } state_t;

    function automatic logic in_win(input logic [15:0] d, input logic [15:0] lo, input logic [15:0] hi);
        return (d >= lo) && (d <= hi);
    endfunction

    logic [1:0]       sync;
    logic             ir;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             lvl;
    logic [15:0]      dur;
    logic             lvl_chg;
    logic             rise;
    logic             fall;
    logic [15:0]      cur_max;
    logic             over;
    logic             chk_ok;

    state_t      state, state_n;
    logic [31:0] sr, sr_n;
    logic [5:0]  bitcnt, bitcnt_n;
    logic        have_frame;
    logic        valid_n, rep_n, err_n, load_n;

    // Idle line is high, so the synchroniser resets to "space".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], i_ir_rxb};
    end

    assign ir   = ~sync[1];
    assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    assign lvl_chg = tick && (ir != lvl);
    assign rise    = lvl_chg && ir;
    assign fall    = lvl_chg && !ir;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl <= 1'b0;
            dur <= '0;
        end else if (tick) begin
            lvl <= ir;
            if (ir != lvl)          dur <= 16'd1;
            else if (dur != 16'hFFFF) dur <= dur + 16'd1;
        end
    end

    always_comb begin
        cur_max = 16'hFFFF;
        case (state)
            LEAD_MARK:          cur_max = LM_MAX;
            LEAD_SPACE:         cur_max = LS_MAX;
            BIT_SPACE:          cur_max = S1_MAX;
            BIT_MARK, REP_MARK: cur_max = BM_MAX;
            default:            cur_max = 16'hFFFF;
        endcase
    end

    // Leaving one tick early (dur == max) means dur would exceed max on this tick.
    assign over   = tick && (dur >= cur_max);
    assign chk_ok = ((CHECK_CMD == 0) || (sr[31:24] == ~sr[23:16])) &&
                    ((EXT_ADDR != 0)  || (sr[15:8]  == ~sr[7:0]));

    always_comb begin
        state_n  = state;
        sr_n     = sr;
        bitcnt_n = bitcnt;
        valid_n  = 1'b0;
        rep_n    = 1'b0;
        err_n    = 1'b0;
        load_n   = 1'b0;
        case (state)
            IDLE: if (rise) state_n = LEAD_MARK;
            LEAD_MARK: begin
                if (fall)      state_n = in_win(dur, LM_MIN, LM_MAX) ? LEAD_SPACE : IDLE;
                else if (over) state_n = IDLE;
            end
            LEAD_SPACE: begin
                if (rise) begin
                    if (in_win(dur, LS_MIN, LS_MAX)) begin
                        state_n  = BIT_MARK;
                        bitcnt_n = '0;
                        sr_n     = '0;
                    end else if (in_win(dur, RS_MIN, RS_MAX)) begin
                        state_n = REP_MARK;
                    end else begin
                        state_n = IDLE;
                        err_n   = 1'b1;
                    end
                end else if (over) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                end
            end
            BIT_MARK: begin
                if (fall) begin
                    if (!in_win(dur, BM_MIN, BM_MAX)) begin
                        state_n = IDLE;
                        err_n   = 1'b1;
                    end else if (bitcnt == 6'd32) begin
                        state_n = IDLE;
                        load_n  = chk_ok;
                        valid_n = chk_ok;
                        err_n   = !chk_ok;
                    end else begin
                        state_n = BIT_SPACE;
                    end
                end else if (over) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                end
            end
            BIT_SPACE: begin
                if (rise) begin
                    if (in_win(dur, S0_MIN, S0_MAX) || in_win(dur, S1_MIN, S1_MAX)) begin
                        sr_n     = {in_win(dur, S1_MIN, S1_MAX), sr[31:1]};
                        bitcnt_n = bitcnt + 6'd1;
                        state_n  = BIT_MARK;
                    end else begin
                        state_n = IDLE;
                        err_n   = 1'b1;
                    end
                end else if (over) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                end
            end
            REP_MARK: begin
                if (fall) begin
                    state_n = IDLE;
                    if (in_win(dur, BM_MIN, BM_MAX) && have_frame) rep_n = 1'b1;
                    else                                           err_n = 1'b1;
                end else if (over) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sr           <= '0;
            bitcnt       <= '0;
            have_frame   <= 1'b0;
            bus.o_data   <= '0;
            bus.o_valid  <= 1'b0;
            bus.o_repeat <= 1'b0;
            bus.o_err    <= 1'b0;
        end else begin
            state        <= state_n;
            sr           <= sr_n;
            bitcnt       <= bitcnt_n;
            bus.o_valid  <= valid_n;
            bus.o_repeat <= rep_n;
            bus.o_err    <= err_n;
            if (load_n) begin
                bus.o_data <= sr;
                have_frame <= 1'b1;
            end
        end
    end

    assign bus.o_busy = (state != IDLE);

endmodule

// File: doc/nec_ir_decoder.md
# nec_ir_decoder

Parametrised NEC infrared remote-control receiver for the board IR sensor input. It timestamps mark and space durations on a derived 1 µs tick and decodes leader, 32-bit frame and repeat codes. Frames are validated against the NEC inverse-byte checksum, and the result is reported with one-cycle strobes. It sits between the raw `i_ir_rxb` pin and display or control logic; `o_data` feeds the FND decoders exactly as the previous receiver did.

## Interface
- `CLK_DIV`, default 50: clk cycles per 1 µs tick. Must be ≥ 2.
- `CHECK_CMD`, default 1: when 1, require `data[31:24] == ~data[23:16]`.
- `EXT_ADDR`, default 0: when 0, require `data[15:8] == ~data[7:0]`. When 1, a 16-bit address is accepted unchecked.
- `clk` input, 1 bit: system clock.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `i_ir_rxb` input, 1 bit: raw IR receiver output, active-low (low = carrier = mark). Asynchronous to `clk`.
- `o_data` output, 32 bits: last valid frame. `[7:0]` address, `[15:8]` address inverse or high byte, `[23:16]` command, `[31:24]` command inverse.
- `o_valid` output, 1 bit: one-clk pulse when a new valid frame has been loaded into `o_data`.
- `o_repeat` output, 1 bit: one-clk pulse on a valid repeat code.
- `o_err` output, 1 bit: one-clk pulse on a malformed frame or repeat code.
- `o_busy` output, 1 bit: high whenever the FSM is not in IDLE.

## Operation
- Input conditioning: 2-flop synchroniser on `i_ir_rxb`, then inversion. `ir` = 1 means mark.
- Tick generator: counter 0..CLK_DIV-1. `tick` is a one-clk pulse when the counter wraps. The counter is free-running and never re-phased.
- Sampling: on each tick, `ir` is sampled into `lvl`. `dur` is a 16-bit saturating tick count of the current level.
  - If the sample differs from `lvl`, an edge occurs: the ending period's length is the old `dur`, and `dur` loads 1.
  - Otherwise `dur` increments, saturating at 0xFFFF.
- Windows, in µs, inclusive:
  - LM leader mark: 8000–10000.
  - LS leader space: 4000–5000.
  - RS repeat space: 2000–2500.
  - BM bit mark: 400–700.
  - S0 zero space: 400–700.
  - S1 one space: 1400–1900.
- FSM states and transitions (edges are evaluated on ticks):
  - IDLE → LEAD_MARK on a mark start.
  - LEAD_MARK, at mark end:
    - duration in LM → LEAD_SPACE.
    - otherwise → IDLE silently (noise rejection, no `o_err`).
  - LEAD_SPACE, at space end:
    - duration in LS → BIT_MARK, with `bitcnt` = 0 and the shift register cleared.
    - duration in RS → REP_MARK.
    - otherwise → IDLE with `o_err`.
  - BIT_MARK, at mark end with duration in BM:
    - if `bitcnt` == 32, this is the stop mark: run the checksum.
      - Pass: load `o_data` from the shift register, pulse `o_valid`, set `have_frame`, go to IDLE.
      - Fail: pulse `o_err`, go to IDLE; `o_data` is unchanged.
    - otherwise → BIT_SPACE.
  - BIT_SPACE, at space end:
    - duration in S0 → shift in 0.
    - duration in S1 → shift in 1.
    - In both cases `bitcnt`++ and go to BIT_MARK.
    - otherwise → IDLE with `o_err`.
  - REP_MARK, at mark end with duration in BM:
    - `have_frame` = 1 → pulse `o_repeat`.
    - `have_frame` = 0 → pulse `o_err`.
    - Go to IDLE in both cases.
  - Any out-of-window mark in BIT_MARK or REP_MARK → IDLE with `o_err`.
- Shift register: LSB first, `sr <= {bit, sr[31:1]}`. After 32 bits the first received bit is at `sr[0]`.
- Timeout: in any non-IDLE state, as soon as `dur` exceeds the maximum of the window set allowed for the current level, the FSM leaves without waiting for the edge.
  - Allowed maxima: LEAD_MARK 10000, LEAD_SPACE 5000, BIT_SPACE 1900, BIT_MARK and REP_MARK 700.
  - LEAD_MARK timeout → IDLE silently. All other timeouts → IDLE with `o_err`.
- Re-entry: after returning to IDLE with the line in mark, nothing happens until the next mark start (space→mark edge).
- `have_frame`: cleared only by reset. A repeat code never modifies `o_data`.

## Timing
- Reset values: `o_data` = 0, `o_valid` = `o_repeat` = `o_err` = 0, `o_busy` = 0, state IDLE, `have_frame` = 0, `dur` = 0, `lvl` = 0 (space).
- Input-to-sample latency: 2 clk of synchroniser plus up to CLK_DIV clk of tick phase.
- Strobes:
  - Each strobe asserts for exactly 1 clk, in the clk cycle after the tick that decided it.
  - At most one strobe asserts per event; they are mutually exclusive.
  - `o_data` updates in the same cycle `o_valid` asserts.
- Duration resolution is ±1 tick. Window comparisons use the tick count directly.
- Reset mid-frame: all state and outputs return to reset values immediately (asynchronous). Decoding restarts only on a fresh leader.

## Test plan
- Frame with addr 0x04, cmd 0x08 at nominal timing → a single `o_valid` pulse; `o_data` = 0xF708FB04; `o_err` never asserts.
- The same frame followed 40 ms later by a repeat code (9000 mark, 2250 space, 560 mark) → one `o_repeat` pulse; `o_data` stays 0xF708FB04.
- Repeat code sent immediately after reset → `o_err` pulse, no `o_repeat`, `o_data` = 0.
- Frame with cmd 0x08 and inverse byte 0xF6, with CHECK_CMD=1 → `o_err`, `o_data` unchanged. Frame with addr 0x1234, cmd 0x08: with EXT_ADDR=1 → `o_valid`, `o_data` = 0xF7081234; with EXT_ADDR=0 → `o_err`.
- Glitches: a 300 µs mark in IDLE, then a 6000 µs mark → no strobes, `o_busy` returns low. A 3000 µs space after bit 5 → `o_err` once `dur` reaches 1901, `o_busy` falls.
- `rst_n` asserted during bit 20, released, then a fresh valid frame sent → strobes stay low during reset; after release, a single correct `o_valid`.
